// File: rtl/bypass_pkg.sv
// Shared types for the integer bypass network: pipeline stage entry layout,
// register-index width and a saturating counter helper.
package bypass_pkg;

`include "core/params.svh"

    localparam int unsigned XLEN  = `XLEN;
    localparam int unsigned REG_W = 5;

    // One in-flight result: destination, and the value once it is known.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             data_valid;
        logic [XLEN-1:0]  data;
    } stage_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/bypass_match.sv
// Youngest-match operand selector for one read port of the bypass network.
// Stage 0 is the youngest entry; the first valid stage whose rd matches wins.
module bypass_match
    import bypass_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  stage_t [DEPTH-1:0] stages_i,
    input  logic [REG_W-1:0]   rs_sel_i,
    input  logic [XLEN-1:0]    rf_data_i,
    output logic [XLEN-1:0]    rs_data_o,
    output logic               rs_stall_o,
    output logic               fwd_o
);

    logic            hit;
    logic            hit_dv;
    logic [XLEN-1:0] hit_data;

    // Priority search from youngest to oldest; register 0 never matches.
    always_comb begin
        hit      = 1'b0;
        hit_dv   = 1'b0;
        hit_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!hit && stages_i[i].valid && (rs_sel_i != '0) &&
                (stages_i[i].rd == rs_sel_i)) begin
                hit      = 1'b1;
                hit_dv   = stages_i[i].data_valid;
                hit_data = stages_i[i].data;
            end
        end
        fwd_o      = hit && hit_dv;
        rs_stall_o = hit && !hit_dv;
        rs_data_o  = fwd_o ? hit_data : rf_data_i;
    end

endmodule

// File: rtl/core/params.svh
// Core-wide build parameters shared by every datapath block.
`ifndef CORE_PARAMS_SVH
`define CORE_PARAMS_SVH

`define XLEN 32

`endif

// File: rtl/int_bypass_net.sv
// Integer bypass network: tracks DEPTH in-flight results, forwards the youngest
// matching value to each read port, flags operands whose producer has no value
// yet, and retires the oldest entry to the register file.
// Optional build macro BYPASS_STATS_EN adds saturating fwd/stall cycle counters.
module int_bypass_net
    import bypass_pkg::*;
#(
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned NREAD      = 2,
    parameter int unsigned LATE_STAGE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        advance,
    input  logic                        issue_valid,
    input  logic [REG_W-1:0]            issue_rd,
    input  logic                        issue_data_valid,
    input  logic [XLEN-1:0]             issue_data,
    input  logic                        late_valid,
    input  logic [XLEN-1:0]             late_data,
    input  logic [NREAD-1:0][REG_W-1:0] rs_sel,
    input  logic [NREAD-1:0][XLEN-1:0]  rf_data,
    output logic [NREAD-1:0][XLEN-1:0]  rs_data,
    output logic [NREAD-1:0]            rs_stall,
    output logic                        wb_valid,
    output logic [REG_W-1:0]            wb_rd,
    output logic [XLEN-1:0]             wb_data
`ifdef BYPASS_STATS_EN
    ,
    output logic [31:0]                 fwd_count,
    output logic [31:0]                 stall_count
`endif
);

    stage_t [DEPTH-1:0] stage_q;
    stage_t [DEPTH-1:0] stage_d;
    stage_t [DEPTH-1:0] filled;

    logic               wb_valid_q, wb_valid_d;
    logic [REG_W-1:0]   wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;

    logic [NREAD-1:0]   port_fwd;

    // Apply a late fill to the entry sitting at LATE_STAGE before any shift,
    // so a fill coinciding with advance travels with its entry.
    always_comb begin
        filled = stage_q;
        if (late_valid && stage_q[LATE_STAGE].valid &&
            !stage_q[LATE_STAGE].data_valid) begin
            filled[LATE_STAGE].data_valid = 1'b1;
            filled[LATE_STAGE].data       = late_data;
        end
    end

    // Shift the pipeline on advance and pick up the retiring oldest entry.
    always_comb begin
        stage_d    = filled;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        if (advance) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_d[i] = filled[i-1];
            end
            stage_d[0].valid      = issue_valid && (issue_rd != '0);
            stage_d[0].rd         = issue_rd;
            stage_d[0].data_valid = issue_data_valid;
            stage_d[0].data       = issue_data;
            if (filled[DEPTH-1].valid && filled[DEPTH-1].data_valid) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = filled[DEPTH-1].rd;
                wb_data_d  = filled[DEPTH-1].data;
            end
        end
    end

    // Pipeline and writeback registers; reset discards all in-flight entries.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            stage_q    <= stage_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        bypass_match #(
            .DEPTH(DEPTH)
        ) u_match (
            .stages_i   (stage_q),
            .rs_sel_i   (rs_sel[p]),
            .rf_data_i  (rf_data[p]),
            .rs_data_o  (rs_data[p]),
            .rs_stall_o (rs_stall[p]),
            .fwd_o      (port_fwd[p])
        );
    end

`ifdef BYPASS_STATS_EN
    logic [31:0] fwd_count_q;
    logic [31:0] stall_count_q;

    // Count cycles with at least one forwarded or stalled operand.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fwd_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            if (|port_fwd) begin
                fwd_count_q <= sat_inc32(fwd_count_q);
            end
            if (|rs_stall) begin
                stall_count_q <= sat_inc32(stall_count_q);
            end
        end
    end

    assign fwd_count   = fwd_count_q;
    assign stall_count = stall_count_q;
`else
    logic unused_port_fwd;
    assign unused_port_fwd = ^port_fwd;
`endif

endmodule

// File: tb/tb_int_bypass_net.sv
// Self-checking bench for int_bypass_net (DEPTH=3, NREAD=2, LATE_STAGE=1).
// Directed vector table, hand sequences for reset and stats, then random
// traffic against a queue-based reference model.
module tb_int_bypass_net;
    import bypass_pkg::*;

    localparam int unsigned DEPTH = 3;
    localparam int unsigned NREAD = 2;
    localparam int unsigned LS    = 1;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        advance;
    logic                        issue_valid;
    logic [REG_W-1:0]            issue_rd;
    logic                        issue_data_valid;
    logic [XLEN-1:0]             issue_data;
    logic                        late_valid;
    logic [XLEN-1:0]             late_data;
    logic [NREAD-1:0][REG_W-1:0] rs_sel;
    logic [NREAD-1:0][XLEN-1:0]  rf_data;
    logic [NREAD-1:0][XLEN-1:0]  rs_data;
    logic [NREAD-1:0]            rs_stall;
    logic                        wb_valid;
    logic [REG_W-1:0]            wb_rd;
    logic [XLEN-1:0]             wb_data;
`ifdef BYPASS_STATS_EN
    logic [31:0]                 fwd_count;
    logic [31:0]                 stall_count;
`endif

    always #5 clk = ~clk;

    int_bypass_net #(
        .DEPTH(DEPTH),
        .NREAD(NREAD),
        .LATE_STAGE(LS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .advance          (advance),
        .issue_valid      (issue_valid),
        .issue_rd         (issue_rd),
        .issue_data_valid (issue_data_valid),
        .issue_data       (issue_data),
        .late_valid       (late_valid),
        .late_data        (late_data),
        .rs_sel           (rs_sel),
        .rf_data          (rf_data),
        .rs_data          (rs_data),
        .rs_stall         (rs_stall),
        .wb_valid         (wb_valid),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data)
`ifdef BYPASS_STATS_EN
        ,
        .fwd_count        (fwd_count),
        .stall_count      (stall_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queue of in-flight results, [0] youngest
    typedef struct {
        bit        valid;
        bit [4:0]  rd;
        bit        dv;
        bit [31:0] data;
    } ment_t;

    ment_t     mq[$];
    bit        m_wbv;
    bit [4:0]  m_wbrd;
    bit [31:0] m_wbd;
    bit [31:0] m_fc;
    bit [31:0] m_sc;

    function automatic void mread(input bit [4:0] sel, input bit [31:0] rf,
                                  output bit [31:0] d, output bit st, output bit fw);
        d  = rf;
        st = 1'b0;
        fw = 1'b0;
        if (sel != 5'd0) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].valid && mq[i].rd == sel) begin
                    if (mq[i].dv) begin
                        d  = mq[i].data;
                        fw = 1'b1;
                    end else begin
                        st = 1'b1;
                    end
                    break;
                end
            end
        end
    endfunction

    task automatic model_reset();
        ment_t e;
        e = '{valid: 1'b0, rd: 5'd0, dv: 1'b0, data: 32'd0};
        mq.delete();
        for (int i = 0; i < DEPTH; i++) mq.push_back(e);
        m_wbv  = 1'b0;
        m_wbrd = 5'd0;
        m_wbd  = 32'd0;
        m_fc   = 32'd0;
        m_sc   = 32'd0;
    endtask

    task automatic model_update();
        bit [31:0] d;
        bit        st, fw, any_f, any_s;
        ment_t     e, old;
        if (!rst) begin
            model_reset();
        end else begin
            any_f = 1'b0;
            any_s = 1'b0;
            for (int p = 0; p < NREAD; p++) begin
                mread(rs_sel[p], rf_data[p], d, st, fw);
                any_f |= fw;
                any_s |= st;
            end
            if (any_f && m_fc != 32'hFFFF_FFFF) m_fc++;
            if (any_s && m_sc != 32'hFFFF_FFFF) m_sc++;
            if (late_valid && mq[LS].valid && !mq[LS].dv) begin
                e = mq[LS];
                e.dv = 1'b1;
                e.data = late_data;
                mq[LS] = e;
            end
            m_wbv = 1'b0;
            if (advance) begin
                old = mq.pop_back();
                if (old.valid && old.dv) begin
                    m_wbv  = 1'b1;
                    m_wbrd = old.rd;
                    m_wbd  = old.data;
                end
                e.valid = issue_valid && (issue_rd != 5'd0);
                e.rd    = issue_rd;
                e.dv    = issue_data_valid;
                e.data  = issue_data;
                mq.push_front(e);
            end
        end
    endtask

    task automatic check_model();
        bit [31:0] d;
        bit        st, fw;
        for (int p = 0; p < NREAD; p++) begin
            mread(rs_sel[p], rf_data[p], d, st, fw);
            chk($sformatf("model rs_data[%0d]", p), 64'(rs_data[p]), 64'(d));
            chk($sformatf("model rs_stall[%0d]", p), 64'(rs_stall[p]), 64'(st));
        end
        chk("model wb_valid", 64'(wb_valid), 64'(m_wbv));
        if (m_wbv) begin
            chk("model wb_rd", 64'(wb_rd), 64'(m_wbrd));
            chk("model wb_data", 64'(wb_data), 64'(m_wbd));
        end
`ifdef BYPASS_STATS_EN
        chk("model fwd_count", 64'(fwd_count), 64'(m_fc));
        chk("model stall_count", 64'(stall_count), 64'(m_sc));
`endif
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit adv, input bit iv, input bit [4:0] ird, input bit idv,
                         input bit [31:0] idat, input bit lv, input bit [31:0] ldat,
                         input bit [4:0] s0, input bit [4:0] s1,
                         input bit [31:0] r0, input bit [31:0] r1);
        rst              = 1'b1;
        advance          = adv;
        issue_valid      = iv;
        issue_rd         = ird;
        issue_data_valid = idv;
        issue_data       = idat;
        late_valid       = lv;
        late_data        = ldat;
        rs_sel[0]        = s0;
        rs_sel[1]        = s1;
        rf_data[0]       = r0;
        rf_data[1]       = r1;
    endtask

    // ---------------- directed vector table
    typedef struct {
        bit        adv, iv;
        bit [4:0]  ird;
        bit        idv;
        bit [31:0] idata;
        bit        lv;
        bit [31:0] ldata;
        bit [4:0]  s0, s1;
        bit [31:0] rf0, rf1;
        bit [31:0] d0;
        bit        st0;
        bit [31:0] d1;
        bit        st1;
        bit        wv;
        bit [4:0]  wrd;
        bit [31:0] wd;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl[NV];

    initial begin
        //            adv   iv    ird   idv   idata          lv    ldata     s0    s1    rf0        rf1        d0             st0   d1             st1   wv    wrd   wd
        tbl[0]  = '{1'b1,1'b1,5'd1,1'b1,32'hFFFF_FFFF,1'b0,32'h0,   5'd1,5'd1,32'h100,32'h200,32'h100,      1'b0,32'h200,      1'b0,1'b0,5'd0,32'h0};
        tbl[1]  = '{1'b0,1'b0,5'd0,1'b0,32'h0,        1'b0,32'h0,   5'd1,5'd1,32'h101,32'h201,32'hFFFF_FFFF,1'b0,32'hFFFF_FFFF,1'b0,1'b0,5'd0,32'h0};
        tbl[2]  = '{1'b1,1'b1,5'd5,1'b0,32'h0,        1'b0,32'h0,   5'd5,5'd1,32'h102,32'h202,32'h102,      1'b0,32'hFFFF_FFFF,1'b0,1'b0,5'd0,32'h0};
        tbl[3]  = '{1'b0,1'b0,5'd0,1'b0,32'h0,        1'b0,32'h0,   5'd5,5'd2,32'h103,32'h203,32'h103,      1'b1,32'h203,      1'b0,1'b0,5'd0,32'h0};
        tbl[4]  = '{1'b1,1'b0,5'd0,1'b0,32'h0,        1'b0,32'h0,   5'd5,5'd1,32'h104,32'h204,32'h104,      1'b1,32'hFFFF_FFFF,1'b0,1'b0,5'd0,32'h0};
        tbl[5]  = '{1'b0,1'b0,5'd0,1'b0,32'h0,        1'b1,32'h55,  5'd5,5'd1,32'h105,32'h205,32'h105,      1'b1,32'hFFFF_FFFF,1'b0,1'b0,5'd0,32'h0};
        tbl[6]  = '{1'b0,1'b0,5'd0,1'b0,32'h0,        1'b0,32'h0,   5'd5,5'd5,32'h106,32'h206,32'h55,       1'b0,32'h55,       1'b0,1'b0,5'd0,32'h0};
        tbl[7]  = '{1'b1,1'b1,5'd3,1'b1,32'h1,        1'b0,32'h0,   5'd3,5'd0,32'h107,32'h207,32'h107,      1'b0,32'h207,      1'b0,1'b0,5'd0,32'h0};
        tbl[8]  = '{1'b1,1'b1,5'd3,1'b1,32'h2,        1'b0,32'h0,   5'd3,5'd5,32'h108,32'h208,32'h1,        1'b0,32'h55,       1'b0,1'b1,5'd1,32'hFFFF_FFFF};
        tbl[9]  = '{1'b0,1'b0,5'd0,1'b0,32'h0,        1'b0,32'h0,   5'd3,5'd3,32'h109,32'h209,32'h2,        1'b0,32'h2,        1'b0,1'b1,5'd5,32'h55};
        tbl[10] = '{1'b1,1'b1,5'd0,1'b1,32'h1234,     1'b0,32'h0,   5'd0,5'd3,32'h0,  32'h20A,32'h0,        1'b0,32'h2,        1'b0,1'b0,5'd0,32'h0};
        tbl[11] = '{1'b1,1'b0,5'd0,1'b0,32'h0,        1'b0,32'h0,   5'd0,5'd3,32'h0,  32'h20B,32'h0,        1'b0,32'h2,        1'b0,1'b0,5'd0,32'h0};
        tbl[12] = '{1'b1,1'b0,5'd0,1'b0,32'h0,        1'b0,32'h0,   5'd0,5'd3,32'h0,  32'h20C,32'h0,        1'b0,32'h2,        1'b0,1'b1,5'd3,32'h1};
        tbl[13] = '{1'b1,1'b0,5'd0,1'b0,32'h0,        1'b0,32'h0,   5'd3,5'd0,32'h10D,32'h20D,32'h10D,      1'b0,32'h20D,      1'b0,1'b1,5'd3,32'h2};
        tbl[14] = '{1'b0,1'b0,5'd0,1'b0,32'h0,        1'b0,32'h0,   5'd0,5'd0,32'h0,  32'h20E,32'h0,        1'b0,32'h20E,      1'b0,1'b0,5'd0,32'h0};
        tbl[15] = '{1'b1,1'b1,5'd7,1'b1,32'h77,       1'b0,32'h0,   5'd7,5'd7,32'h10F,32'h20F,32'h10F,      1'b0,32'h20F,      1'b0,1'b0,5'd0,32'h0};
        tbl[16] = '{1'b1,1'b0,5'd0,1'b0,32'h0,        1'b1,32'h99,  5'd7,5'd6,32'h110,32'h210,32'h77,       1'b0,32'h210,      1'b0,1'b0,5'd0,32'h0};
        tbl[17] = '{1'b0,1'b0,5'd0,1'b0,32'h0,        1'b1,32'h99,  5'd7,5'd7,32'h111,32'h211,32'h77,       1'b0,32'h77,       1'b0,1'b0,5'd0,32'h0};
        tbl[18] = '{1'b0,1'b0,5'd0,1'b0,32'h0,        1'b0,32'h0,   5'd7,5'd1,32'h112,32'h212,32'h77,       1'b0,32'h212,      1'b0,1'b0,5'd0,32'h0};
        tbl[19] = '{1'b1,1'b1,5'd9,1'b0,32'h0,        1'b0,32'h0,   5'd9,5'd7,32'h113,32'h213,32'h113,      1'b0,32'h77,       1'b0,1'b0,5'd0,32'h0};
        tbl[20] = '{1'b1,1'b0,5'd0,1'b0,32'h0,        1'b0,32'h0,   5'd9,5'd9,32'h114,32'h214,32'h114,      1'b1,32'h214,      1'b1,1'b0,5'd0,32'h0};
        tbl[21] = '{1'b1,1'b0,5'd0,1'b0,32'h0,        1'b1,32'hAB,  5'd9,5'd7,32'h115,32'h215,32'h115,      1'b1,32'h215,      1'b0,1'b1,5'd7,32'h77};
        tbl[22] = '{1'b0,1'b0,5'd0,1'b0,32'h0,        1'b0,32'h0,   5'd9,5'd9,32'h116,32'h216,32'hAB,       1'b0,32'hAB,       1'b0,1'b0,5'd0,32'h0};
        tbl[23] = '{1'b1,1'b0,5'd0,1'b0,32'h0,        1'b0,32'h0,   5'd0,5'd0,32'h0,  32'h217,32'h0,        1'b0,32'h217,      1'b0,1'b0,5'd0,32'h0};
        tbl[24] = '{1'b0,1'b0,5'd0,1'b0,32'h0,        1'b0,32'h0,   5'd9,5'd0,32'h118,32'h218,32'h118,      1'b0,32'h218,      1'b0,1'b1,5'd9,32'hAB};
    end

    // ---------------- main sequence
    initial begin
        drive(1'b1, 1'b1, 5'd1, 1'b1, 32'hDEAD, 1'b1, 32'hBEEF, 5'd0, 5'd0, 32'h0, 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;

        // Reset state
        drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd1, 5'd2, 32'hA1, 32'hA2);
        @(negedge clk);
        chk("reset wb_valid", 64'(wb_valid), 64'd0);
        chk("reset wb_rd", 64'(wb_rd), 64'd0);
        chk("reset wb_data", 64'(wb_data), 64'd0);
        chk("reset rs_data0", 64'(rs_data[0]), 64'hA1);
        chk("reset rs_stall", 64'(rs_stall), 64'd0);
`ifdef BYPASS_STATS_EN
        chk("reset fwd_count", 64'(fwd_count), 64'd0);
        chk("reset stall_count", 64'(stall_count), 64'd0);
`endif
        @(posedge clk);
        model_update();
        #1;

        // Directed table
        for (int v = 0; v < NV; v++) begin
            drive(tbl[v].adv, tbl[v].iv, tbl[v].ird, tbl[v].idv, tbl[v].idata,
                  tbl[v].lv, tbl[v].ldata, tbl[v].s0, tbl[v].s1, tbl[v].rf0, tbl[v].rf1);
            @(negedge clk);
            check_model();
            chk($sformatf("vec%0d rs_data0", v), 64'(rs_data[0]), 64'(tbl[v].d0));
            chk($sformatf("vec%0d rs_stall0", v), 64'(rs_stall[0]), 64'(tbl[v].st0));
            chk($sformatf("vec%0d rs_data1", v), 64'(rs_data[1]), 64'(tbl[v].d1));
            chk($sformatf("vec%0d rs_stall1", v), 64'(rs_stall[1]), 64'(tbl[v].st1));
            chk($sformatf("vec%0d wb_valid", v), 64'(wb_valid), 64'(tbl[v].wv));
            if (tbl[v].wv) begin
                chk($sformatf("vec%0d wb_rd", v), 64'(wb_rd), 64'(tbl[v].wrd));
                chk($sformatf("vec%0d wb_data", v), 64'(wb_data), 64'(tbl[v].wd));
            end
            @(posedge clk);
            model_update();
            #1;
        end

        // Fill every stage, then reset for one cycle while advancing and filling
        for (int k = 1; k <= DEPTH; k++) begin
            drive(1'b1, 1'b1, 5'(k), 1'b1, 32'h1100 + 32'(k), 1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0);
            step();
        end
        drive(1'b1, 1'b1, 5'd4, 1'b0, 32'h0, 1'b1, 32'h66, 5'd1, 5'd2, 32'h0, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        model_update();
        #1;
        for (int k = 0; k < DEPTH + 1; k++) begin
            drive(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd1, 5'd2, 32'hC1, 32'hC2);
            @(negedge clk);
            chk($sformatf("post-rst%0d rs_data0", k), 64'(rs_data[0]), 64'hC1);
            chk($sformatf("post-rst%0d rs_data1", k), 64'(rs_data[1]), 64'hC2);
            chk($sformatf("post-rst%0d rs_stall", k), 64'(rs_stall), 64'd0);
            chk($sformatf("post-rst%0d wb_valid", k), 64'(wb_valid), 64'd0);
`ifdef BYPASS_STATS_EN
            chk($sformatf("post-rst%0d fwd_count", k), 64'(fwd_count), 64'd0);
            chk($sformatf("post-rst%0d stall_count", k), 64'(stall_count), 64'd0);
`endif
            @(posedge clk);
            model_update();
            #1;
        end

`ifdef BYPASS_STATS_EN
        // Three forwarding cycles and two stall cycles from a clean reset
        drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        model_update();
        #1;
        drive(1'b1, 1'b1, 5'd2, 1'b1, 32'h22, 1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0); step();
        drive(1'b1, 1'b1, 5'd4, 1'b0, 32'h0,  1'b0, 32'h0, 5'd2, 5'd2, 32'h0, 32'h0); step();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0,  1'b0, 32'h0, 5'd2, 5'd4, 32'h0, 32'h0); step();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0,  1'b0, 32'h0, 5'd2, 5'd0, 32'h0, 32'h0); step();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0,  1'b0, 32'h0, 5'd4, 5'd4, 32'h0, 32'h0); step();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0,  1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("stats fwd_count", 64'(fwd_count), 64'd3);
        chk("stats stall_count", 64'(stall_count), 64'd2);
        @(posedge clk);
        model_update();
        #1;
`endif

        // Random traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)),
                  $urandom(),
                  ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                  $urandom(),
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  $urandom(),
                  $urandom());
            rst = ($urandom_range(0, 39) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/int_bypass_net.md
INT_BYPASS_NET -- requirements
Module: int_bypass_net

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 3, giving the number of in-flight result stages tracked (legal range 1..8).
REQ-002 The block SHALL have the parameter NREAD, default 2, giving the number of operand read ports.
REQ-003 The block SHALL have the parameter LATE_STAGE, default 1, giving the stage index at which late (load/multi-cycle) results are filled (0..DEPTH-1).
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 advance  in  1  pipeline moves one stage this cycle.
REQ-007 issue_valid  in  1  an instruction with a destination enters stage 0 on advance.
REQ-008 issue_rd  in  5  destination register.
REQ-009 issue_data_valid  in  1  result is already known at issue (ALU).
REQ-010 issue_data  in  XLEN  result value when issue_data_valid.
REQ-011 late_valid  in  1  fill the entry at stage LATE_STAGE.
REQ-012 late_data  in  XLEN  late result value.
REQ-013 rs_sel  in  NREAD x 5  source register per read port.
REQ-014 rf_data  in  NREAD x XLEN  register-file read data per port.
REQ-015 rs_data  out  NREAD x XLEN  forwarded or register-file operand.
REQ-016 rs_stall  out  NREAD  operand depends on an entry whose result is not yet valid.
REQ-017 wb_valid, wb_rd, wb_data  out  1/5/XLEN  retiring write to the register file.

Function
REQ-018 Each stage SHALL hold {valid, rd, data_valid, data}; on advance, stage i moves to stage i+1 and stage 0 loads the issue fields (valid = issue_valid and issue_rd != 0).
REQ-019 Without advance, all stages SHALL hold their contents, except as allowed by REQ-020.
REQ-020 When late_valid is asserted, the entry currently at stage LATE_STAGE SHALL set data_valid=1 and data=late_data; with simultaneous advance the filled entry SHALL land in stage LATE_STAGE+1.
REQ-021 late_valid targeting an invalid entry or an entry with data_valid=1 SHALL be ignored.
REQ-022 wb_valid/wb_rd/wb_data SHALL be registered outputs equal to the stage DEPTH-1 entry shifted out on advance (one-cycle pulse); an entry leaving with data_valid=0 SHALL NOT assert wb_valid.
REQ-023 Each read port SHALL select the youngest (lowest-index) valid stage whose rd equals rs_sel, combinationally with zero latency.
REQ-024 On a match with data_valid=1, rs_data SHALL equal that entry's data and rs_stall SHALL be 0.
REQ-025 On a match with data_valid=0, rs_stall SHALL be 1 and rs_data SHALL equal rf_data.
REQ-026 With no match, or with rs_sel=0, rs_data SHALL equal rf_data and rs_stall SHALL be 0; register 0 SHALL never match.
REQ-027 Read ports SHALL be independent; identical rs_sel on two ports SHALL give identical results.

Reset
REQ-028 While rst=0 at a rising edge, all stage valid and data_valid bits SHALL clear, wb_valid=0, wb_rd=0, and wb_data=0; reset SHALL override advance and late_valid.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries without producing a writeback.

Configuration
REQ-030 With BYPASS_STATS_EN defined, the block SHALL add 32-bit outputs fwd_count and stall_count: fwd_count increments once per cycle in which any port forwards (REQ-024), and stall_count increments once per cycle in which any rs_stall=1; both saturate at all-ones and clear on reset.
REQ-031 Without BYPASS_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 The stage entry struct typedef and the register-index width constant SHALL live in a shared package bypass_pkg; XLEN SHALL come from core/params.svh.
REQ-033 The per-port youngest-match priority selector SHALL be a sub-module bypass_match, instantiated NREAD times.

Verification
REQ-034 Issue rd=1, data=0xFFFFFFFF, data_valid=1, then read rs_sel=1 on the next cycle -> rs_data=0xFFFFFFFF, rs_stall=0.
REQ-035 Issue rd=5 with data_valid=0, then read rs_sel=5 -> rs_stall=1; advance to stage LATE_STAGE and assert late_valid with 0x55 -> the next cycle gives rs_data=0x55, rs_stall=0.
REQ-036 Issue rd=3 with value 1, then rd=3 with value 2 -> the read returns 2 (youngest); after DEPTH+1 advances, wb shows rd=3/1 and then rd=3/2.
REQ-037 Issue rd=0 with value 0x1234 and read rs_sel=0 with rf_data=0 -> rs_data=0, no stall, and no wb_valid ever.
REQ-038 Fill all DEPTH stages, pull rst low for one cycle -> all reads return rf_data, wb_valid stays 0, and stats counters (if enabled) read 0.
REQ-039 With BYPASS_STATS_EN, drive 3 forwarding cycles and 2 stall cycles -> fwd_count=3, stall_count=2.
